switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/sw_pkg.sv | 17 +
 rtl/sync_2ff.sv | 25 ++
 rtl/switch_debouncer.sv | 100 ++++++++++
 tb/tb_switch_debouncer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// sw_pkg: shared definitions for the push-button debounce path.
//   sw_state_e           - debouncer FSM states (2-bit encoding)
//   CLK_HZ               - board clock frequency
//   DEBOUNCE_CYCLES_10MS - 10 ms expressed in CLK_HZ cycles
package sw_pkg;

  localparam int unsigned CLK_HZ               = 25_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_10MS = 250_000;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_HIGH     = 2'd2,
    ST_FALL_CHK = 2'd3
  } sw_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk_i - destination clock
//   rst_i - synchronous active-high reset, clears both flops
//   d_i   - asynchronous input
//   q_o   - synchronized output (second flop)
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta <= 1'b0;
      q_o  <= 1'b0;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: debounces a bouncing push-button.
//   clk_i         - 25 MHz clock, all state on rising edge
//   rst_i         - synchronous active-high reset
//   sw_i          - raw asynchronous button level
//   sw_o          - debounced level
//   rise_o        - one-cycle strobe on accepted 0->1 (press)
//   fall_o        - one-cycle strobe on accepted 1->0 (release)
//   press_count_o - accepted press count, wraps 255->0
// A level change is accepted only after the synchronized input has held the
// new level for STABLE_CYCLES consecutive checks; any glitch back restarts.
module switch_debouncer
  import sw_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_10MS
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sw_i,
  output logic       sw_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic [7:0] press_count_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync;
  sw_state_e        state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (sw_i),
    .q_o   (sync)
  );

  // Strobes default low every cycle so each accepted edge yields exactly one
  // pulse; sw_o only moves on the same edge that raises a strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_LOW;
      cnt           <= '0;
      sw_o          <= 1'b0;
      rise_o        <= 1'b0;
      fall_o        <= 1'b0;
      press_count_o <= '0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      unique case (state)
        ST_LOW: begin
          if (sync) begin
            state <= ST_RISE_CHK;
            cnt   <= '0;
          end
        end
        ST_RISE_CHK: begin
          if (!sync) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= ST_HIGH;
            cnt           <= '0;
            sw_o          <= 1'b1;
            rise_o        <= 1'b1;
            press_count_o <= press_count_o + 8'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (!sync) begin
            state <= ST_FALL_CHK;
            cnt   <= '0;
          end
        end
        ST_FALL_CHK: begin
          if (sync) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= ST_LOW;
            cnt    <= '0;
            sw_o   <= 1'b0;
            fall_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  localparam int S = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       sw_i  = 1'b0;
  logic       sw_o, rise_o, fall_o;
  logic [7:0] press_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  switch_debouncer #(.STABLE_CYCLES(S)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sw_i          (sw_i),
    .sw_o          (sw_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .press_count_o (press_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: the debounced level flips once the input, seen two samples
  // late, has disagreed with it on S+1 consecutive edges (first sighting
  // plus S qualifying checks).
  bit       hist[$];
  int       m_run;
  bit       m_level, m_rise, m_fall;
  bit [7:0] m_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit sw, input bit rst);
    bit seen;
    if (rst) begin
      hist = '{1'b0, 1'b0};
      m_run = 0; m_level = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
    end else begin
      seen = hist[0];
      void'(hist.pop_front());
      hist.push_back(sw);
      m_rise = 0; m_fall = 0;
      m_run = (seen != m_level) ? m_run + 1 : 0;
      if (m_run == S + 1) begin
        m_level = seen;
        m_run = 0;
        if (m_level) begin m_rise = 1; m_cnt = m_cnt + 8'd1; end
        else m_fall = 1;
      end
    end
  endtask

  task automatic tick(input bit sw, input bit rst);
    sw_i  = sw;
    rst_i = rst;
    @(posedge clk_i);
    model_step(sw, rst);
    #1;
    chk("sw_o",  int'(sw_o),  int'(m_level));
    chk("rise_o", int'(rise_o), int'(m_rise));
    chk("fall_o", int'(fall_o), int'(m_fall));
    chk("count", int'(press_count_o), int'(m_cnt));
    if (rise_o && fall_o) chk("rise_and_fall", 1, 0);
  endtask

  int pc;
  int seg_len;
  bit seg_val;

  initial begin
    hist = '{1'b0, 1'b0};
    // reset state
    for (int i = 0; i < 3; i++) tick(0, 1);
    chk("rst_sw", int'(sw_o), 0);
    chk("rst_cnt", int'(press_count_o), 0);

    // press latency: rise exactly after edge S+2
    for (int e = 0; e <= 10; e++) begin
      tick(1, 0);
      chk("lat_rise", int'(rise_o), int'(e == S + 2));
    end
    chk("lat_sw", int'(sw_o), 1);
    chk("lat_cnt", int'(press_count_o), 1);

    // bounce from LOW is filtered
    tick(0, 1);
    for (int i = 0; i < 4; i++) tick(0, 0);
    pc = int'(press_count_o);
    begin
      bit pat [6] = '{1, 1, 0, 1, 1, 0};
      for (int i = 0; i < 16; i++) begin
        tick(i < 6 ? pat[i] : 1'b0, 0);
        chk("bnc_rise", int'(rise_o), 0);
        chk("bnc_sw", int'(sw_o), 0);
      end
    end
    chk("bnc_cnt", int'(press_count_o), pc);

    // release latency from HIGH
    for (int i = 0; i < 10; i++) tick(1, 0);
    pc = int'(press_count_o);
    for (int e = 0; e <= 10; e++) begin
      tick(0, 0);
      chk("rel_fall", int'(fall_o), int'(e == S + 2));
    end
    chk("rel_sw", int'(sw_o), 0);
    chk("rel_cnt", int'(press_count_o), pc);

    // 256 clean presses wrap the counter
    tick(0, 1);
    for (int p = 1; p <= 256; p++) begin
      for (int i = 0; i < 8; i++) tick(1, 0);
      if (p == 255) chk("wrap_255", int'(press_count_o), 255);
      if (p == 256) chk("wrap_0", int'(press_count_o), 0);
      for (int i = 0; i < 8; i++) tick(0, 0);
    end

    // reset mid-check aborts, press re-qualifies afterwards
    tick(0, 1);
    tick(0, 1);
    for (int e = 0; e <= 4; e++) tick(1, 0);
    tick(1, 1);
    chk("abort_rise", int'(rise_o), 0);
    chk("abort_sw", int'(sw_o), 0);
    chk("abort_cnt", int'(press_count_o), 0);
    for (int e = 0; e <= 8; e++) begin
      tick(1, 0);
      chk("requal_rise", int'(rise_o), int'(e == S + 2));
    end

    // random bursts with occasional reset
    for (int n = 0; n < 400; n++) begin
      seg_len = $urandom_range(1, 9);
      seg_val = 1'($urandom_range(0, 1));
      for (int i = 0; i < seg_len; i++)
        tick(seg_val, $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
